// File: rtl/rice_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : rice_encoder_if
//  Brief    : Sample-in / word-out handshake bundle for rice_encoder.
//  Revision : 1.0
// ============================================================================
interface rice_encoder_if;
   logic        go;
   logic [5:0]  n;
   logic [5:0]  j;
   logic [5:0]  k;
   logic [31:0] sample_in;
   logic        sample_valid;
   logic        sample_ready;
   logic [31:0] word_out;
   logic        word_valid;
   logic        word_ready;
   logic        busy;
   logic        block_done;

   modport slave (
      input  go, n, j, k, sample_in, sample_valid, word_ready,
      output sample_ready, word_out, word_valid, busy, block_done
   );

   modport master (
      output go, n, j, k, sample_in, sample_valid, word_ready,
      input  sample_ready, word_out, word_valid, busy, block_done
   );
endinterface
`default_nettype wire

// File: rtl/rice_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : rice_encoder
//  Brief    : Golomb-Rice block encoder packing a 6-bit k header plus j
//             codewords into an MSB-first 32-bit word stream.
//  Revision : 1.0
// ============================================================================
module rice_encoder #(
   parameter int WORD_W = 32,
   parameter int HDR_W  = 6
) (
   input  wire logic     clk1,
   input  wire logic     reset,
   rice_encoder_if.slave bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HDR   = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_ZERO  = 3'd3;
   localparam logic [2:0] S_TERM  = 3'd4;
   localparam logic [2:0] S_FLUSH = 3'd5;

   logic [2:0]        r_state;
   logic [5:0]        r_n;
   logic [5:0]        r_k;
   logic [6:0]        r_cnt;
   logic [31:0]       r_q;
   logic [31:0]       r_r;
   logic              r_ph;
   logic [WORD_W-1:0] r_acc;
   logic [5:0]        r_fill;
   logic [WORD_W-1:0] r_word;
   logic              r_wvalid;
   logic              r_done;

   logic                w_can;
   logic                w_drain;
   logic                w_app;
   logic                w_full;
   logic [5:0]          w_len;
   logic [5:0]          w_space;
   logic [31:0]         w_bits;
   logic [6:0]          w_sum;
   logic [6:0]          w_sh;
   logic [2*WORD_W-1:0] w_cat;
   logic [5:0]          w_neff;
   logic [5:0]          w_keff;
   logic [31:0]         w_samp;
   logic [31:0]         w_qn;
   logic [31:0]         w_rn;

   // Every append waits while the output register holds an undrained word.
   assign w_drain = r_wvalid & bus.word_ready;
   assign w_can   = ~r_wvalid | bus.word_ready;
   assign w_space = 6'd32 - r_fill;

   assign w_neff = (bus.n == 6'd0) ? 6'd1 : ((bus.n > 6'd32) ? 6'd32 : bus.n);
   assign w_keff = (bus.k > w_neff) ? w_neff : bus.k;
   assign w_samp = bus.sample_in & (32'hFFFF_FFFF >> (6'd32 - r_n));
   assign w_qn   = w_samp >> r_k;
   assign w_rn   = w_samp & ~(32'hFFFF_FFFF << r_k);

   always_comb begin
      w_app  = 1'b0;
      w_len  = 6'd0;
      w_bits = 32'd0;
      case (r_state)
         S_HDR: begin
            w_app  = w_can;
            w_len  = 6'(HDR_W);
            w_bits = {26'd0, r_k};
         end
         S_ZERO: begin
            w_app = w_can;
            w_len = (r_q < {26'd0, w_space}) ? r_q[5:0] : w_space;
         end
         S_TERM: begin
            w_app = w_can;
            // A 33-bit terminator field (k=32) goes out as the 1 alone, then r.
            if (r_ph) begin
               w_len  = 6'd32;
               w_bits = r_r;
            end else if (r_k == 6'd32) begin
               w_len  = 6'd1;
               w_bits = 32'd1;
            end else begin
               w_len  = r_k + 6'd1;
               w_bits = r_r | (32'd1 << r_k);
            end
         end
         S_FLUSH: begin
            w_app = w_can & (r_fill != 6'd0);
            w_len = w_space;
         end
         default: begin
            w_app = 1'b0;
         end
      endcase
   end

   assign w_sum  = {1'b0, r_fill} + {1'b0, w_len};
   assign w_full = (w_sum >= 7'd32);
   assign w_sh   = 7'd64 - w_sum;
   assign w_cat  = {r_acc, 32'd0} | ({32'd0, w_bits} << w_sh);

   always_ff @(posedge clk1 or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_n      <= 6'd0;
         r_k      <= 6'd0;
         r_cnt    <= 7'd0;
         r_q      <= 32'd0;
         r_r      <= 32'd0;
         r_ph     <= 1'b0;
         r_acc    <= '0;
         r_fill   <= 6'd0;
         r_word   <= '0;
         r_wvalid <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_drain) begin
            r_wvalid <= 1'b0;
         end
         if (w_app) begin
            if (w_full) begin
               r_word   <= w_cat[63:32];
               r_wvalid <= 1'b1;
               r_acc    <= w_cat[31:0];
               r_fill   <= {1'b0, w_sum[4:0]};
            end else begin
               r_acc    <= w_cat[63:32];
               r_fill   <= w_sum[5:0];
            end
         end
         case (r_state)
            S_IDLE: begin
               if (bus.go) begin
                  r_n     <= w_neff;
                  r_k     <= w_keff;
                  r_cnt   <= (bus.j == 6'd0) ? 7'd64 : {1'b0, bus.j};
                  r_state <= S_HDR;
               end
            end
            S_HDR: begin
               if (w_can) r_state <= S_LOAD;
            end
            S_LOAD: begin
               if (bus.sample_valid && w_can) begin
                  r_q     <= w_qn;
                  r_r     <= w_rn;
                  r_ph    <= 1'b0;
                  r_state <= (w_qn != 32'd0) ? S_ZERO : S_TERM;
               end
            end
            S_ZERO: begin
               if (w_can) begin
                  r_q <= r_q - {26'd0, w_len};
                  if (r_q == {26'd0, w_len}) r_state <= S_TERM;
               end
            end
            S_TERM: begin
               if (w_can) begin
                  if (r_k == 6'd32 && !r_ph) begin
                     r_ph <= 1'b1;
                  end else begin
                     r_cnt   <= r_cnt - 7'd1;
                     r_state <= (r_cnt == 7'd1) ? S_FLUSH : S_LOAD;
                  end
               end
            end
            S_FLUSH: begin
               if (r_fill == 6'd0 && (!r_wvalid || bus.word_ready)) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.sample_ready = (r_state == S_LOAD) & w_can;
   assign bus.word_out     = r_word;
   assign bus.word_valid   = r_wvalid;
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.block_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rice_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rice_encoder
//  Brief    : Randomised bench for rice_encoder with a bit-queue stream model.
//  Revision : 1.0
// ============================================================================
module tb_rice_encoder;

   logic clk1  = 1'b0;
   logic reset = 1'b0;

   rice_encoder_if bus ();

   rice_encoder dut (
      .clk1  (clk1),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk1 = ~clk1;

   int          tests    = 0;
   int          fails    = 0;
   int          rdy_mode = 0;
   logic [31:0] smp_q[$];
   logic [31:0] mdl_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   logic [31:0] prev_word;
   bit          prev_stall;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: build the block as a flat bit list, then cut into 32-bit words.
   function automatic void build_model(input int n, input int jn, input int k);
      bit                b[$];
      int                ne, jj, ke;
      longint unsigned   v, q, r;
      logic [31:0]       word;
      ne = (n == 0) ? 1 : ((n > 32) ? 32 : n);
      jj = (jn == 0) ? 64 : jn;
      ke = (k > ne) ? ne : k;
      mdl_q.delete();
      for (int i = 5; i >= 0; i--) b.push_back(bit'((ke >> i) & 1));
      for (int s = 0; s < jj; s++) begin
         v = 64'(smp_q[s]) % (64'd1 << ne);
         q = v >> ke;
         r = v % (64'd1 << ke);
         for (longint unsigned z = 0; z < q; z++) b.push_back(1'b0);
         b.push_back(1'b1);
         for (int i = ke - 1; i >= 0; i--) b.push_back(bit'((r >> i) & 1));
      end
      while (b.size() % 32 != 0) b.push_back(1'b0);
      for (int w = 0; w < b.size() / 32; w++) begin
         word = 32'd0;
         for (int i = 0; i < 32; i++) word = {word[30:0], b[w*32+i]};
         mdl_q.push_back(word);
      end
   endfunction

   initial forever begin
      @(posedge clk1);
      #1;
      case (rdy_mode)
         0:       bus.word_ready = 1'b1;
         1:       bus.word_ready = ($urandom % 3) != 0;
         default: bus.word_ready = 1'b0;
      endcase
   end

   always @(negedge clk1) begin
      if (!reset) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 32'(bus.word_valid), 32'd1);
            chk("hold_data", bus.word_out, prev_word);
         end
         if (bus.word_valid && bus.word_ready) begin
            got_q.push_back(bus.word_out);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_word: actual=%h required=none", bus.word_out);
            end else begin
               chk("word", bus.word_out, exp_q.pop_front());
            end
         end
         prev_stall <= bus.word_valid && !bus.word_ready;
         prev_word  <= bus.word_out;
      end
   end

   task automatic send_sample(input logic [31:0] s, input string tag);
      int budget;
      repeat ($urandom % 3) begin
         @(posedge clk1);
         #1;
      end
      bus.sample_in    = s;
      bus.sample_valid = 1'b1;
      budget = 0;
      do begin
         @(negedge clk1);
         budget++;
      end while (!bus.sample_ready && budget < 2000);
      if (!bus.sample_ready) begin
         tests++;
         fails++;
         $display("FAIL %s_sample_timeout: actual=no_ready required=ready", tag);
      end
      @(posedge clk1);
      #1;
      bus.sample_valid = 1'b0;
      bus.sample_in    = $urandom;
   endtask

   task automatic start_block(input int n, input int jn, input int k, input string tag);
      build_model(n, jn, k);
      foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
      got_q.delete();
      @(posedge clk1);
      #1;
      bus.go = 1'b1;
      bus.n  = 6'(n);
      bus.j  = 6'(jn);
      bus.k  = 6'(k);
      @(posedge clk1);
      #1;
      bus.go = 1'b0;
      bus.n  = 6'($urandom);
      bus.j  = 6'($urandom);
      bus.k  = 6'($urandom);
      chk({tag, "_busy_high"}, 32'(bus.busy), 32'd1);
   endtask

   task automatic run_block(input int n, input int jn, input int k, input bit stall5, input string tag);
      int jj, budget;
      jj = (jn == 0) ? 64 : jn;
      start_block(n, jn, k, tag);
      for (int s = 0; s < jj; s++) begin
         send_sample(smp_q[s], tag);
         if (s == 0 && jj > 1) begin
            bus.go = 1'b1;
            @(posedge clk1);
            #1;
            bus.go = 1'b0;
         end
      end
      if (stall5) begin
         budget = 0;
         do begin
            @(negedge clk1);
            budget++;
         end while (!bus.word_valid && budget < 500);
         for (int c = 0; c < 5; c++) begin
            chk({tag, "_stall_valid"}, 32'(bus.word_valid), 32'd1);
            chk({tag, "_stall_word"}, bus.word_out, 32'h0960_0000);
            chk({tag, "_stall_sready"}, 32'(bus.sample_ready), 32'd0);
            if (c < 4) @(negedge clk1);
         end
         rdy_mode = 0;
      end
      budget = 0;
      do begin
         @(negedge clk1);
         budget++;
      end while (!bus.block_done && budget < 5000);
      chk({tag, "_block_done"}, 32'(bus.block_done), 32'd1);
      chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
      chk({tag, "_nwords"}, 32'(got_q.size()), 32'(mdl_q.size()));
      chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
      @(negedge clk1);
      chk({tag, "_done_pulse"}, 32'(bus.block_done), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_word_out"}, bus.word_out, 32'd0);
      chk({tag, "_word_valid"}, 32'(bus.word_valid), 32'd0);
      chk({tag, "_sample_ready"}, 32'(bus.sample_ready), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_block_done"}, 32'(bus.block_done), 32'd0);
   endtask

   initial begin
      int n, jn, k, ne, ke;
      longint unsigned v;
      logic [31:0] g;

      bus.go           = 1'b0;
      bus.n            = 6'd0;
      bus.j            = 6'd0;
      bus.k            = 6'd0;
      bus.sample_in    = 32'd0;
      bus.sample_valid = 1'b0;
      bus.word_ready   = 1'b1;
      repeat (3) @(posedge clk1);
      #1;
      check_reset_outputs("reset");
      reset = 1'b1;

      smp_q = '{32'h8000_0405, 32'h0000_FC00};
      run_block(10, 2, 2, 1'b0, "tp1");
      chk("tp1_model", mdl_q[0], 32'h0960_0000);
      chk("tp1_w0", got_q[0], 32'h0960_0000);

      smp_q = '{32'd40};
      run_block(16, 1, 0, 1'b0, "tp2");
      chk("tp2_model_w1", mdl_q[1], 32'h0002_0000);
      chk("tp2_w0", got_q[0], 32'h0000_0000);
      chk("tp2_w1", got_q[1], 32'h0002_0000);

      smp_q = '{32'h0000_000F};
      run_block(4, 1, 6, 1'b0, "tp3");
      chk("tp3_model", mdl_q[0], 32'h13E0_0000);
      chk("tp3_w0", got_q[0], 32'h13E0_0000);

      smp_q = '{32'h0000_0ABC, 32'h0000_0123};
      run_block(16, 2, 12, 1'b0, "tp4");
      chk("tp4_model_n", 32'(mdl_q.size()), 32'd1);
      chk("tp4_w0", got_q[0], 32'h3357_9123);

      rdy_mode = 2;
      smp_q = '{32'd5, 32'd0};
      run_block(10, 2, 2, 1'b1, "tp5");
      chk("tp5_w0", got_q[0], 32'h0960_0000);

      rdy_mode = 1;
      for (int t = 0; t < 40; t++) begin
         n  = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 32);
         jn = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 6);
         k  = ($urandom % 4 == 0) ? $urandom_range(32, 63) : $urandom_range(0, 31);
         ne = (n == 0) ? 1 : n;
         ke = (k > ne) ? ne : k;
         smp_q.delete();
         for (int s = 0; s < 64; s++) begin
            v = (64'($urandom_range(0, 70)) << ke) | (64'($urandom) % (64'd1 << ke));
            v = v % (64'd1 << ne);
            g = $urandom;
            g = (ne == 32) ? 32'd0 : (g << ne);
            smp_q.push_back(32'(v) | g);
         end
         run_block(n, jn, k, 1'b0, "rand");
      end

      smp_q = '{32'd3000};
      run_block(32, 1, 0, 1'b0, "longq");

      rdy_mode = 0;
      smp_q = '{32'd100000};
      start_block(32, 1, 0, "rst");
      send_sample(smp_q[0], "rst");
      repeat (20) @(posedge clk1);
      #3;
      reset = 1'b0;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete();
      repeat (2) @(posedge clk1);
      #1;
      reset = 1'b1;
      repeat (3) @(negedge clk1);
      chk("midrst_no_done", 32'(bus.block_done), 32'd0);

      smp_q = '{32'd5, 32'd0};
      run_block(10, 2, 2, 1'b0, "tp6");
      chk("tp6_w0", got_q[0], 32'h0960_0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
